// File: rtl/rasterizer_plane_scan.sv
// Raster walker: evaluates edge and parameter plane equations incrementally, one pixel per accepted beat.
// Latency: first pixel is valid the cycle after start is sampled. Back-pressure: outputs hold while m_valid && !m_ready.
module rasterizer_plane_scan #(
    parameter int X_WIDTH     = 12,
    parameter int Y_WIDTH     = 12,
    parameter int EDGE_NUM    = 3,
    parameter int EDGE_WIDTH  = 20,
    parameter int PARAM_NUM   = 3,
    parameter int PARAM_WIDTH = 20
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    input  logic [X_WIDTH-1:0]               x_num,
    input  logic [Y_WIDTH-1:0]               y_num,
    input  logic [EDGE_NUM*EDGE_WIDTH-1:0]   edge_offset,
    input  logic [EDGE_NUM*EDGE_WIDTH-1:0]   edge_dx,
    input  logic [EDGE_NUM*EDGE_WIDTH-1:0]   edge_dy_stride,
    input  logic [PARAM_NUM*PARAM_WIDTH-1:0] param_offset,
    input  logic [PARAM_NUM*PARAM_WIDTH-1:0] param_dx,
    input  logic [PARAM_NUM*PARAM_WIDTH-1:0] param_dy_stride,
    output logic [X_WIDTH-1:0]               m_x,
    output logic [Y_WIDTH-1:0]               m_y,
    output logic                             m_frame_start,
    output logic                             m_line_end,
    output logic [EDGE_NUM-1:0]              m_edge_flag,
    output logic                             m_inside,
    output logic [PARAM_NUM*PARAM_WIDTH-1:0] m_param,
    output logic                             m_valid,
    input  logic                             m_ready
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    localparam int EW = EDGE_NUM * EDGE_WIDTH;
    localparam int PW = PARAM_NUM * PARAM_WIDTH;
    localparam logic [X_WIDTH-1:0] X_ONE = 1;
    localparam logic [Y_WIDTH-1:0] Y_ONE = 1;

    logic [0:0]          state_q;
    logic [X_WIDTH-1:0]  x_q, x_num_q, x_nxt, x_lim;
    logic [Y_WIDTH-1:0]  y_q, y_num_q, y_nxt;
    logic [EW-1:0]       edge_dx_q, edge_dys_q, edge_acc_q, edge_nxt;
    logic [PW-1:0]       param_dx_q, param_dys_q, param_acc_q, param_nxt;
    logic [EDGE_NUM-1:0] flag_q, flag_nxt;
    logic                valid_q, done_q, frame_start_q, line_end_q;
    logic                load, accept, last_x, last_y;

    assign load   = (state_q == IDLE) && start && (x_num != '0) && (y_num != '0);
    assign accept = valid_q && m_ready;
    assign last_x = (x_q == x_num_q - X_ONE);
    assign last_y = (y_q == y_num_q - Y_ONE);

    // Next coordinates and accumulators; the final accept leaves everything in place.
    always_comb begin
        x_nxt     = x_q;
        y_nxt     = y_q;
        x_lim     = x_num_q;
        edge_nxt  = edge_acc_q;
        param_nxt = param_acc_q;
        if (load) begin
            x_nxt     = '0;
            y_nxt     = '0;
            x_lim     = x_num;
            edge_nxt  = edge_offset;
            param_nxt = param_offset;
        end else if (accept && !last_x) begin
            x_nxt = x_q + X_ONE;
            for (int i = 0; i < EDGE_NUM; i++)
                edge_nxt[i*EDGE_WIDTH +: EDGE_WIDTH] =
                    edge_acc_q[i*EDGE_WIDTH +: EDGE_WIDTH] + edge_dx_q[i*EDGE_WIDTH +: EDGE_WIDTH];
            for (int i = 0; i < PARAM_NUM; i++)
                param_nxt[i*PARAM_WIDTH +: PARAM_WIDTH] =
                    param_acc_q[i*PARAM_WIDTH +: PARAM_WIDTH] + param_dx_q[i*PARAM_WIDTH +: PARAM_WIDTH];
        end else if (accept && !last_y) begin
            x_nxt = '0;
            y_nxt = y_q + Y_ONE;
            for (int i = 0; i < EDGE_NUM; i++)
                edge_nxt[i*EDGE_WIDTH +: EDGE_WIDTH] =
                    edge_acc_q[i*EDGE_WIDTH +: EDGE_WIDTH] + edge_dys_q[i*EDGE_WIDTH +: EDGE_WIDTH];
            for (int i = 0; i < PARAM_NUM; i++)
                param_nxt[i*PARAM_WIDTH +: PARAM_WIDTH] =
                    param_acc_q[i*PARAM_WIDTH +: PARAM_WIDTH] + param_dys_q[i*PARAM_WIDTH +: PARAM_WIDTH];
        end
    end

    always_comb begin
        flag_nxt = '0;
        for (int i = 0; i < EDGE_NUM; i++)
            flag_nxt[i] = ~edge_nxt[i*EDGE_WIDTH + EDGE_WIDTH - 1];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            valid_q       <= 1'b0;
            done_q        <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            x_num_q       <= '0;
            y_num_q       <= '0;
            edge_dx_q     <= '0;
            edge_dys_q    <= '0;
            param_dx_q    <= '0;
            param_dys_q   <= '0;
            edge_acc_q    <= '0;
            param_acc_q   <= '0;
            flag_q        <= '0;
            frame_start_q <= 1'b0;
            line_end_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load) begin
                        state_q     <= RUN;
                        valid_q     <= 1'b1;
                        x_num_q     <= x_num;
                        y_num_q     <= y_num;
                        edge_dx_q   <= edge_dx;
                        edge_dys_q  <= edge_dy_stride;
                        param_dx_q  <= param_dx;
                        param_dys_q <= param_dy_stride;
                    end
                end
                RUN: begin
                    if (accept && last_x && last_y) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
            x_q           <= x_nxt;
            y_q           <= y_nxt;
            edge_acc_q    <= edge_nxt;
            param_acc_q   <= param_nxt;
            flag_q        <= flag_nxt;
            frame_start_q <= (x_nxt == '0) && (y_nxt == '0);
            line_end_q    <= (x_nxt == x_lim - X_ONE);
        end
    end

    assign busy          = (state_q == RUN);
    assign done          = done_q;
    assign m_valid       = valid_q;
    assign m_x           = x_q;
    assign m_y           = y_q;
    assign m_frame_start = frame_start_q;
    assign m_line_end    = line_end_q;
    assign m_edge_flag   = flag_q;
    assign m_inside      = &flag_q;
    assign m_param       = param_acc_q;

endmodule
